pipeline_skid_reg: RTL and testbench

PIPELINE_SKID_REG -- requirements
Module: pipeline_skid_reg

---
 rtl/pipeline_skid_reg.sv | 94 +++++++++
 tb/tb_pipeline_skid_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_skid_reg
// Brief    : Two-entry valid/ready pipeline stage with registered out_data and
//            in_ready decoded only from state, so out_ready never reaches in_ready.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_skid_reg #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_pop;

    // Readiness comes from the state register alone; reset only masks it.
    assign w_in_ready  = ((r_state == S_EMPTY) || (r_state == S_BUSY)) && !reset;
    assign w_out_valid = (r_state == S_BUSY) || (r_state == S_FULL);
    assign w_accept    = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;

    always_comb begin
        occupancy = 2'd0;
        case (r_state)
            S_BUSY:  occupancy = 2'd1;
            S_FULL:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state <= S_EMPTY;
            r_main  <= RESET_VALUE;
            r_skid  <= RESET_VALUE;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= in_data;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_accept && !w_pop) begin
                        r_skid  <= in_data;
                        r_state <= S_FULL;
                    end else if (w_accept && w_pop) begin
                        r_main  <= in_data;
                    end else if (!w_accept && w_pop) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // Skid entry is older than anything upstream, so it moves up first.
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= S_BUSY;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_skid_reg
// Brief    : Scenario tasks plus random stress against a FIFO-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_skid_reg;

    localparam int unsigned      WIDTH = 16;
    localparam logic [WIDTH-1:0] RV    = 16'h5A5A;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_idle = RV;

    pipeline_skid_reg #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Advance one edge and update the queue model from the inputs seen there.
    task automatic tick();
        bit m_rdy, acc, pp;
        @(posedge clk);
        m_rdy = !reset && (q.size() < 2);
        acc   = in_valid && m_rdy;
        pp    = (q.size() > 0) && out_ready;
        if (reset || flush) begin
            q.delete();
            m_idle = RV;
        end else begin
            if (pp) m_idle = q.pop_front();
            if (acc) q.push_back(in_data);
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_during got=%b want=0", in_ready); end
        tick(); tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_hold got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
        total++; if (out_data !== RV) begin bad++; $display("FAIL reset_data got=%h want=%h", out_data, RV); end
        reset = 0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_stream();
        idle_inputs();
        out_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1; in_data = WIDTH'(i);
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(i) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_%0d got v=%b d=%h occ=%0d rdy=%b want v=1 d=%h occ=1 rdy=1",
                         i, out_valid, out_data, occupancy, in_ready, WIDTH'(i));
            end
        end
        in_valid = 0;
        tick();
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL stream_drain got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_back_to_back_backpressure();
        idle_inputs();
        in_valid = 1; in_data = 16'h000A; tick();
        in_data = 16'h000B; tick();
        in_data = 16'h00EE;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h000A || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_full_%0d got occ=%0d rdy=%b d=%h v=%b want occ=2 rdy=0 d=000a v=1",
                         i, occupancy, in_ready, out_data, out_valid);
            end
            tick();
        end
        in_valid = 0; out_ready = 1;
        #1;
        total++; if (out_data !== 16'h000A) begin bad++; $display("FAIL bp_first got=%h want=000a", out_data); end
        tick();
        total++;
        if (in_ready !== 1'b1 || out_data !== 16'h000B || occupancy !== 2'd1) begin
            bad++;
            $display("FAIL bp_second got rdy=%b d=%h occ=%0d want rdy=1 d=000b occ=1", in_ready, out_data, occupancy);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 1; in_data = 16'h0001; tick();
        in_data = 16'h0002; tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_prefill got=%0d want=2", occupancy); end
        flush = 1; in_data = 16'h000C; out_ready = 1;
        tick();
        flush = 0; in_valid = 0;
        #1;
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== RV) begin
            bad++;
            $display("FAIL flush_after got occ=%0d v=%b rdy=%b d=%h want occ=0 v=0 rdy=1 d=%h",
                     occupancy, out_valid, in_ready, out_data, RV);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak_%0d got v=%b d=%h want v=0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_reset_busy_full();
        idle_inputs();
        in_valid = 1; in_data = 16'h0033; tick();
        in_valid = 0; reset = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rbusy_ready got=%b want=0", in_ready); end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== RV || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rbusy_state got v=%b d=%h rdy=%b want v=0 d=%h rdy=0", out_valid, out_data, in_ready, RV);
        end
        reset = 0;
        in_valid = 1; in_data = 16'h0077;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rbusy_release got=%b want=1", in_ready); end
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'h0077) begin bad++; $display("FAIL rbusy_first got v=%b d=%h want v=1 d=0077", out_valid, out_data); end
        in_valid = 1; in_data = 16'h0078; tick();
        in_valid = 0; reset = 1; tick();
        reset = 0; out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL rfull_drop_%0d got v=%b occ=%0d want v=0 occ=0", i, out_valid, occupancy); end
            tick();
        end
    endtask

    task automatic test_random_stress();
        int n_pop = 0;
        logic [WIDTH-1:0] want;
        idle_inputs();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 999) < 5);
            in_data   = WIDTH'($urandom);
            #1;
            want = (q.size() > 0) ? q[0] : m_idle;
            total++;
            if (out_valid !== (q.size() > 0) || occupancy !== 2'(q.size()) ||
                in_ready !== (q.size() < 2) || out_data !== want) begin
                bad++;
                $display("FAIL stress_c%0d got v=%b occ=%0d rdy=%b d=%h want v=%b occ=%0d rdy=%b d=%h",
                         c, out_valid, occupancy, in_ready, out_data,
                         q.size() > 0, q.size(), q.size() < 2, want);
            end
            if (out_valid && out_ready) n_pop++;
            tick();
        end
        idle_inputs();
        total++; if (n_pop < 1000) begin bad++; $display("FAIL stress_pops got=%0d want>=1000", n_pop); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stream();
        test_back_to_back_backpressure();
        test_flush();
        test_reset_busy_full();
        test_random_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
